// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: redirect sources and instruction size.
package pc_sequencer_pkg;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [2:0] {
    SEQ,
    BR_PCREL,
    BR_REG,
    RET,
    EXC,
    HOLD
  } redir_e;
endpackage

// File: rtl/pc_sequencer_if.sv
// Control and status bundle between the front end and the PC sequencer.
interface pc_sequencer_if #(
  parameter int ADDR_W    = 64,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic [ADDR_W-1:0] SignExtImm64;
  logic [ADDR_W-1:0] RegTarget;
  logic              Branch;
  logic              ALUZero;
  logic              Uncondbranch;
  logic              BranchReg;
  logic              Link;
  logic              Ret;
  logic              Stall;
  logic              Exception;
  logic [ADDR_W-1:0] PC;
  logic [ADDR_W-1:0] NextPC;
  logic [CNT_W-1:0]  RASCount;
  logic              RASOverflow;

  modport master (
    output SignExtImm64, RegTarget, Branch, ALUZero, Uncondbranch,
           BranchReg, Link, Ret, Stall, Exception,
    input  PC, NextPC, RASCount, RASOverflow
  );

  modport slave (
    input  SignExtImm64, RegTarget, Branch, ALUZero, Uncondbranch,
           BranchReg, Link, Ret, Stall, Exception,
    output PC, NextPC, RASCount, RASOverflow
  );
endinterface

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack; a push into a full stack overwrites the oldest entry.
module pc_ras #(
  parameter int ADDR_W    = 64,
  parameter int RAS_DEPTH = 4,
  localparam int PTR_W    = $clog2(RAS_DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              clr,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);
  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  sp;
  logic [PTR_W-1:0]  sp_m1;

  // sp is the next write slot; when full it also points at the oldest entry
  assign sp_m1 = sp - PTR_W'(1);
  assign top   = mem[sp_m1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      sp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (push) begin
      sp <= sp + PTR_W'(1);
      if (count == CNT_W'(RAS_DEPTH)) overflow <= 1'b1;
      else                            count    <= count + CNT_W'(1);
    end else if (pop && count != '0) begin
      sp    <= sp_m1;
      count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem[sp] <= din;
  end
endmodule

// File: rtl/pc_sequencer.sv
// Program counter with prioritised redirect selection and a return-address stack.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                ADDR_W     = 64,
  parameter int                RAS_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(64'h100)
) (
  input logic          CLK,
  input logic          Resetn,
  pc_sequencer_if.slave bus
);
  localparam int                CNT_W = $clog2(RAS_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN = ~(ADDR_W'(INSTR_BYTES - 1));

  logic [ADDR_W-1:0] pc_q, pc_seq, pc_rel, ras_top, nxt;
  logic [CNT_W-1:0]  ras_cnt;
  logic              ras_ovf, push, pop, clr;
  redir_e            src;

  assign pc_seq = pc_q + STEP;
  assign pc_rel = pc_q + (bus.SignExtImm64 << 2);

  always_comb begin
    src  = SEQ;
    push = 1'b0;
    pop  = 1'b0;
    clr  = 1'b0;
    if (bus.Exception) begin
      src = EXC;
      clr = 1'b1;
    end else if (bus.Stall) begin
      src = HOLD;
    end else if (bus.Ret) begin
      src = RET;
      pop = (ras_cnt != '0);
    end else if (bus.BranchReg) begin
      src  = BR_REG;
      push = bus.Link;
    end else if ((bus.Branch && bus.ALUZero) || bus.Uncondbranch) begin
      src  = BR_PCREL;
      // a conditional-only taken branch never links
      push = bus.Link && bus.Uncondbranch;
    end
  end

  always_comb begin
    nxt = pc_seq;
    case (src)
      EXC:      nxt = EXC_VECTOR;
      HOLD:     nxt = pc_q;
      RET:      nxt = (pop ? ras_top : bus.RegTarget) & ALIGN;
      BR_REG:   nxt = bus.RegTarget & ALIGN;
      BR_PCREL: nxt = pc_rel;
      default:  nxt = pc_seq;
    endcase
  end

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) pc_q <= RESET_PC;
    else         pc_q <= nxt;
  end

  pc_ras #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk      (CLK),
    .rst_n    (Resetn),
    .push     (push),
    .pop      (pop),
    .clr      (clr),
    .din      (pc_seq),
    .top      (ras_top),
    .count    (ras_cnt),
    .overflow (ras_ovf)
  );

  assign bus.PC          = pc_q;
  assign bus.NextPC      = nxt;
  assign bus.RASCount    = ras_cnt;
  assign bus.RASOverflow = ras_ovf;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: directed vector table, corner sequences, random run against a queue model.
module tb_pc_sequencer;
  localparam int AW = 64;
  localparam int D  = 4;
  localparam logic [63:0] MASK = ~64'h3;

  logic CLK    = 1'b0;
  logic Resetn = 1'b0;

  pc_sequencer_if #(.ADDR_W(AW), .RAS_DEPTH(D)) bus ();

  pc_sequencer #(
    .ADDR_W(AW), .RAS_DEPTH(D), .RESET_PC(64'h0), .EXC_VECTOR(64'h100)
  ) dut (
    .CLK(CLK), .Resetn(Resetn), .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic br, z, ub, breg, link, ret, stall, exc;
    logic [63:0] imm, regt;
  } in_t;

  typedef struct {
    in_t         stim;
    logic [63:0] pc;
    int          cnt;
    bit          ovf;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // reference model: PC plus a queue of return addresses (newest at back)
  logic [63:0] m_pc;
  logic [63:0] m_ras[$];
  bit          m_ovf;
  vec_t        tbl[$];

  function automatic in_t mk(input bit br, z, ub, breg, link, ret, stall, exc,
                             input logic [63:0] imm, regt);
    in_t v;
    v.br = br; v.z = z; v.ub = ub; v.breg = breg; v.link = link;
    v.ret = ret; v.stall = stall; v.exc = exc; v.imm = imm; v.regt = regt;
    return v;
  endfunction

  task automatic add(input in_t s, input logic [63:0] pc, input int cnt, input bit ovf);
    vec_t t;
    t.stim = s; t.pc = pc; t.cnt = cnt; t.ovf = ovf;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input in_t v);
    bus.Branch = v.br; bus.ALUZero = v.z; bus.Uncondbranch = v.ub;
    bus.BranchReg = v.breg; bus.Link = v.link; bus.Ret = v.ret;
    bus.Stall = v.stall; bus.Exception = v.exc;
    bus.SignExtImm64 = v.imm; bus.RegTarget = v.regt;
  endtask

  task automatic m_push(input logic [63:0] a);
    m_ras.push_back(a);
    if (m_ras.size() > D) begin
      void'(m_ras.pop_front());
      m_ovf = 1'b1;
    end
  endtask

  task automatic model(input in_t v, output logic [63:0] npc);
    if (v.exc) begin
      npc = 64'h100;
      m_ras.delete();
      m_ovf = 1'b0;
    end else if (v.stall) begin
      npc = m_pc;
    end else if (v.ret) begin
      if (m_ras.size() > 0) npc = m_ras.pop_back() & MASK;
      else                  npc = v.regt & MASK;
    end else if (v.breg) begin
      npc = v.regt & MASK;
      if (v.link) m_push(m_pc + 64'd4);
    end else if ((v.br && v.z) || v.ub) begin
      npc = m_pc + (v.imm << 2);
      if (v.link && v.ub) m_push(m_pc + 64'd4);
    end else begin
      npc = m_pc + 64'd4;
    end
    m_pc = npc;
  endtask

  task automatic m_reset();
    m_pc = 64'h0;
    m_ras.delete();
    m_ovf = 1'b0;
  endtask

  // one clock: drive, check combinational NextPC, clock, check registered state
  task automatic cyc(input in_t v);
    logic [63:0] e;
    drive(v);
    #1;
    model(v, e);
    chk("nextpc", bus.NextPC, e);
    @(posedge CLK);
    #1;
    chk("pc", bus.PC, m_pc);
    chk("rascount", 64'(bus.RASCount), 64'(m_ras.size()));
    chk("rasovf", 64'(bus.RASOverflow), 64'(m_ovf));
  endtask

  initial begin
    in_t idle, v;
    logic [7:0] r;
    idle = mk(0,0,0,0,0,0,0,0, 64'h0, 64'h0);

    // br z ub breg link ret stall exc imm regt
    add(idle, 64'h4, 0, 0);
    add(idle, 64'h8, 0, 0);
    add(idle, 64'hc, 0, 0);
    add(mk(0,0,0,1,0,0,0,0, 64'h0, 64'h40), 64'h40, 0, 0);
    add(mk(1,1,0,0,0,0,0,0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0), 64'h38, 0, 0);
    add(mk(0,0,0,1,0,0,0,0, 64'h0, 64'h40), 64'h40, 0, 0);
    add(mk(1,0,0,0,0,0,0,0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0), 64'h44, 0, 0);
    add(mk(0,0,0,1,0,0,0,0, 64'h0, 64'h1003), 64'h1000, 0, 0);
    add(mk(0,0,1,0,1,0,0,0, 64'h10, 64'h0), 64'h1040, 1, 0);
    add(mk(0,0,0,0,0,1,0,0, 64'h0, 64'h0), 64'h1004, 0, 0);
    add(mk(0,0,0,0,0,1,0,0, 64'h0, 64'h2002), 64'h2000, 0, 0);
    add(mk(1,1,0,0,0,0,1,0, 64'h5, 64'h0), 64'h2000, 0, 0);
    add(mk(1,1,0,0,1,0,0,0, 64'h1, 64'h0), 64'h2004, 0, 0);
    add(mk(0,0,0,1,1,0,0,0, 64'h0, 64'h3000), 64'h3000, 1, 0);
    add(mk(0,0,0,0,1,1,0,0, 64'h0, 64'h5000), 64'h2008, 0, 0);
    add(mk(0,0,1,1,0,0,0,0, 64'h1, 64'h4000), 64'h4000, 0, 0);
    add(mk(0,0,0,1,0,1,0,0, 64'h0, 64'h6000), 64'h6000, 0, 0);
    add(mk(0,0,0,1,0,0,0,0, 64'h0, 64'h0), 64'h0, 0, 0);
    add(mk(0,0,1,0,0,0,0,0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0), 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
    add(idle, 64'h0, 0, 0);

    drive(idle);
    m_reset();
    #12;
    chk("reset_pc", bus.PC, 64'h0);
    chk("reset_cnt", 64'(bus.RASCount), 64'h0);
    chk("reset_ovf", 64'(bus.RASOverflow), 64'h0);
    chk("reset_nextpc", bus.NextPC, 64'h4);
    Resetn = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].stim);
      chk($sformatf("tbl%0d_pc", i), bus.PC, tbl[i].pc);
      chk($sformatf("tbl%0d_cnt", i), 64'(bus.RASCount), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d_ovf", i), 64'(bus.RASOverflow), 64'(tbl[i].ovf));
    end

    // five linked calls into a four-deep stack, then unwind
    cyc(mk(0,0,0,0,0,0,0,1, 64'h0, 64'h0));
    chk("exc_pc", bus.PC, 64'h100);
    for (int k = 0; k < 5; k++) cyc(mk(0,0,1,0,1,0,0,0, 64'h4, 64'h0));
    chk("ovf_pc", bus.PC, 64'h150);
    chk("ovf_cnt", 64'(bus.RASCount), 64'd4);
    chk("ovf_flag", 64'(bus.RASOverflow), 64'd1);
    for (int k = 0; k < 4; k++) begin
      cyc(mk(0,0,0,0,0,1,0,0, 64'h0, 64'h9000));
      chk($sformatf("ret%0d_pc", k), bus.PC, 64'h144 - 64'(16 * k));
    end
    cyc(mk(0,0,0,0,0,1,0,0, 64'h0, 64'h2000));
    chk("ret_empty_pc", bus.PC, 64'h2000);
    chk("ovf_sticky", 64'(bus.RASOverflow), 64'd1);

    // stall holds everything, exception beats stall
    cyc(mk(0,0,1,0,1,0,0,0, 64'h4, 64'h0));
    chk("call_pc", bus.PC, 64'h2010);
    for (int k = 0; k < 2; k++) begin
      cyc(mk(1,1,0,0,1,0,1,0, 64'h8, 64'h0));
      chk("stall_pc", bus.PC, 64'h2010);
      chk("stall_cnt", 64'(bus.RASCount), 64'd1);
    end
    cyc(mk(1,1,1,0,1,0,1,1, 64'h8, 64'h0));
    chk("excstall_pc", bus.PC, 64'h100);
    chk("excstall_cnt", 64'(bus.RASCount), 64'd0);
    chk("excstall_ovf", 64'(bus.RASOverflow), 64'd0);

    // asynchronous reset in the middle of a cycle
    cyc(mk(0,0,0,1,1,0,0,0, 64'h0, 64'h88));
    chk("pre_rst_pc", bus.PC, 64'h88);
    #2;
    Resetn = 1'b0;
    m_reset();
    drive(idle);
    #1;
    chk("async_rst_pc", bus.PC, 64'h0);
    chk("async_rst_cnt", 64'(bus.RASCount), 64'd0);
    chk("rst_nextpc", bus.NextPC, 64'h4);
    @(posedge CLK);
    #1;
    chk("rst_hold_pc", bus.PC, 64'h0);
    #2;
    Resetn = 1'b1;
    cyc(idle);
    chk("post_rst_pc", bus.PC, 64'h4);

    for (int n = 0; n < 400; n++) begin
      r = 8'($urandom);
      v.br    = 1'($urandom);
      v.z     = 1'($urandom);
      v.ub    = ($urandom_range(0, 2) == 0);
      v.breg  = ($urandom_range(0, 3) == 0);
      v.link  = 1'($urandom);
      v.ret   = ($urandom_range(0, 3) == 0);
      v.stall = ($urandom_range(0, 7) == 0);
      v.exc   = ($urandom_range(0, 15) == 0);
      v.imm   = {{56{r[7]}}, r};
      v.regt  = {$urandom, $urandom};
      cyc(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 64, PC/address width in bits.
REQ-002 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >=2).
REQ-003 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 Parameter EXC_VECTOR, default 64'h100 (truncated to ADDR_W), exception entry address.
REQ-005 CLK  in  1  sole clock, rising edge.
REQ-006 Resetn  in  1  reset; asynchronous assert, active-low.
REQ-007 SignExtImm64  in  ADDR_W  sign-extended word offset for PC-relative branches.
REQ-008 RegTarget  in  ADDR_W  register-sourced target (BR/RET fallback).
REQ-009 Branch, ALUZero, Uncondbranch  in  1 each  conditional-branch, zero flag, unconditional-branch.
REQ-010 BranchReg  in  1  jump to RegTarget.
REQ-011 Link  in  1  with a taken Uncondbranch or BranchReg, push PC+4 on the RAS.
REQ-012 Ret  in  1  return; pop RAS.
REQ-013 Stall  in  1  hold PC and RAS.
REQ-014 Exception  in  1  redirect to EXC_VECTOR, clear RAS.
REQ-015 PC  out  ADDR_W  registered current PC.
REQ-016 NextPC  out  ADDR_W  combinational value PC will take at next edge.
REQ-017 RASCount  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
REQ-018 RASOverflow  out  1  sticky; set when a push overwrites an entry.

Function
REQ-019 Redirect priority SHALL be: Exception > Stall > Ret > BranchReg > (Branch&ALUZero)|Uncondbranch > sequential.
REQ-020 Sequential: NextPC = PC + 4; PC-relative taken: NextPC = PC + (SignExtImm64 << 2); all sums modulo 2^ADDR_W, no overflow flag.
REQ-021 BranchReg: NextPC = RegTarget.
REQ-022 Ret with RASCount>0: NextPC = top entry, RASCount decrements; Ret with RASCount==0: NextPC = RegTarget, RAS unchanged.
REQ-023 Push (Link & (Uncondbranch|BranchReg), no higher-priority redirect) stores PC+4; Link with only conditional Branch or no branch SHALL be ignored.
REQ-024 Push when RASCount==RAS_DEPTH SHALL overwrite the oldest entry (circular), RASCount stays RAS_DEPTH, RASOverflow set.
REQ-025 Ret and Link together: pop only, Link ignored.
REQ-026 Stall: NextPC = PC, RAS and RASCount unchanged, all other controls ignored.
REQ-027 Exception: NextPC = EXC_VECTOR, RASCount -> 0, RASOverflow -> 0, regardless of Stall.
REQ-028 PC SHALL update to NextPC on every rising CLK edge while Resetn high; latency one cycle.
REQ-029 PC bits [1:0] SHALL be forced to 0 on load from RegTarget or RAS.

Reset
REQ-030 Resetn low SHALL immediately force PC=RESET_PC, RASCount=0, RASOverflow=0, independent of CLK.
REQ-031 NextPC during reset SHALL reflect inputs against PC=RESET_PC; first edge after release loads NextPC.
REQ-032 RAS storage contents need no reset; only RASCount/pointer define validity.

Structure
REQ-033 Shared package: redirect-source enum (SEQ, BR_PCREL, BR_REG, RET, EXC, HOLD) and INSTR_BYTES=4 constant.
REQ-034 One sub-module: pc_ras (circular stack, push/pop/clear, count, overflow); PC register and target mux stay in pc_sequencer.

Verification
REQ-035 Reset release, no controls, 3 edges -> PC 0,4,8,12.
REQ-036 PC=0x40, Branch=1, ALUZero=1, SignExtImm64=-2 -> PC=0x38; ALUZero=0 -> PC=0x44.
REQ-037 PC=0x1000, Uncondbranch=1, Link=1, Imm=0x10 -> PC=0x1040, RASCount=1; then Ret -> PC=0x1004, RASCount=0.
REQ-038 Five pushes with RAS_DEPTH=4 -> RASCount=4, RASOverflow=1; four Rets return the last four PC+4 values newest-first; fifth Ret with RegTarget=0x2000 -> PC=0x2000.
REQ-039 Stall=1 with Branch taken for 2 cycles -> PC and RASCount unchanged; Exception with Stall=1 -> PC=0x100, RASCount=0.
REQ-040 Resetn pulsed low mid-cycle with PC=0x88 -> PC=RESET_PC before next edge, RASCount=0.
